serv_mtimer: RTL and testbench
==============================

// Module: serv_mtimer
// PURPOSE
//  Machine timer peripheral: the source of the timer interrupt line (mtip) consumed by the core CSR unit.
//  Holds a 64-bit free-running mtime and a 64-bit mtimecmp, both reachable as four 32-bit words over a
//  Wishbone-classic slave port. Asserts o_mtip while mtime >= mtimecmp. Sits on the peripheral bus beside RAM/GPIO.
// PARAMETERS
//  PRESCALE        1        i_clk cycles per mtime increment (>=1; 1 = every cycle)
//  RESET_STRATEGY  "MINI"   "NONE": no reset on any flop; any other value: reset as listed below
// PORTS
//  i_clk       in   1   clock
//  i_rst       in   1   reset; synchronous, active-high
//  i_wb_adr    in   2   word select (byte addr [3:2]): 0 mtime_lo, 1 mtime_hi, 2 mtimecmp_lo, 3 mtimecmp_hi
//  i_wb_dat    in   32  write data
//  i_wb_sel    in   4   byte enables, bit n -> dat[8n+7:8n]
//  i_wb_we     in   1   1 = write
//  i_wb_cyc    in   1   bus cycle valid
//  i_wb_stb    in   1   strobe
//  o_wb_rdt    out  32  read data, valid while o_wb_ack=1
//  o_wb_ack    out  1   single-cycle acknowledge
//  o_mtip      out  1   timer interrupt pending, level, to core CSR mtip input
// BEHAVIOUR
//  Reset: mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, prescaler=0, hi_shadow=0, o_wb_ack=0, o_mtip=0, o_wb_rdt=0.
//  Handshake:
//   - req = i_wb_cyc & i_wb_stb & ~o_wb_ack; o_wb_ack=1 exactly one cycle after req, then 0 for >=1 cycle.
//   - Writes take effect on the clock edge that raises o_wb_ack; o_wb_rdt registered on that same edge.
//   - Master holding stb across ack sees acks on alternate cycles only (no back-to-back ack).
//   - Cycle dropped (cyc=0) while ack pending: ack still pulses, write still commits; master ignores it.
//  Prescaler: counts 0..PRESCALE-1; tick=1 when count==PRESCALE-1, count wraps to 0. PRESCALE=1 -> tick every cycle.
//  mtime: +1 (64-bit, carry lo->hi same cycle) on tick; 64'hFFFF..FF wraps to 0, o_mtip follows the compare.
//  Register writes (byte-masked by i_wb_sel):
//   - mtime_lo/hi write replaces that word; on the write cycle the tick increment is suppressed for the
//     whole 64-bit value (write wins; carry from lo into hi is dropped). Prescaler is not reset by writes.
//   - mtimecmp_lo/hi write: plain byte-masked update, no side effects.
//  Reads:
//   - Reading mtime_lo returns current mtime[31:0] and latches mtime[63:32] into hi_shadow in the same cycle.
//   - Reading mtime_hi returns hi_shadow (coherent 64-bit read = lo then hi). mtimecmp reads return live value.
//   - Reads have no other side effect; o_wb_rdt holds its last value when ack=0.
//  Interrupt:
//   - o_mtip registered: o_mtip <= (mtime >= mtimecmp), unsigned 64-bit, using values pre-update.
//     Latency 1 cycle after the edge where the condition first holds.
//   - Level, not pulse; clears only via mtimecmp write raising cmp above mtime, a mtime write, or wrap.
//   - Edge detection is the consumer's job (core forms new_irq on rising edge).
//  Reset mid-transaction: pending ack dropped, write not committed, all state to reset values.
// STRUCTURE
//  serv_mtimer_pkg: register word offsets (MTIME_LO=0, MTIME_HI=1, MTIMECMP_LO=2, MTIMECMP_HI=3) and
//   MTIMECMP_RST=64'hFFFF_FFFF_FFFF_FFFF, shared with software headers and the bench.
//  Sub-module serv_mtimer_prescaler (PRESCALE, i_clk, i_rst -> o_tick); rest is flat: bus FSM
//   (IDLE/ACK), byte-masked register file, 64-bit incrementer, comparator.
// TESTING
//  1 Reset, no access, PRESCALE=1: after 10 cycles read lo -> 10 (+/-ack latency const); o_mtip stays 0.
//  2 Write cmp_hi=0, cmp_lo=20: o_mtip rises exactly 1 cycle after mtime reaches 20; write cmp_lo=FFFF_FFFF -> o_mtip=0 next cycle.
//  3 Write mtime_hi=0, mtime_lo=FFFF_FFFF; read lo then hi after carry -> hi reads 1; read lo before carry,
//    hi after carry -> hi reads 0 (shadow coherent).
//  4 PRESCALE=4: mtime increments once per 4 cycles; write mtime_lo=5 on a tick cycle -> reads 5, not 6.
//  5 Byte writes: cmp_lo=0, then sel=4'b0100, dat=32'h00AB_0000 -> cmp_lo reads 32'h00AB_0000.
//  6 stb held high 6 cycles -> exactly 3 ack pulses; i_rst asserted during pending write -> no commit, ack=0.

Source files
------------

// File: rtl/serv_mtimer_pkg.sv
// Register map, reset constants and bus-FSM states for the machine timer.
// Shared by the RTL, the bench and the software headers.
package serv_mtimer_pkg;

  localparam logic [1:0] MTIME_LO    = 2'd0;
  localparam logic [1:0] MTIME_HI    = 2'd1;
  localparam logic [1:0] MTIMECMP_LO = 2'd2;
  localparam logic [1:0] MTIMECMP_HI = 2'd3;

  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } bus_state_t;

  // Replace only the bytes of old_w whose enable bit is set.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] dat,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) res[8*i +: 8] = dat[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/serv_mtimer_prescaler.sv
// Divides i_clk down to a one-cycle o_tick every PRESCALE cycles (combinational from the count).
// No backpressure; the count free-runs and is only cleared by reset.
module serv_mtimer_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign o_tick = (PRESCALE <= 1) || (count_q == CW'(PRESCALE - 1));

  always_comb begin
    count_d = o_tick ? '0 : count_q + 1'b1;
    if (i_rst) count_d = '0;
  end

  always_ff @(posedge i_clk) begin
    count_q <= count_d;
  end

endmodule

// File: rtl/serv_mtimer.sv
// Machine timer: 64-bit mtime/mtimecmp over a Wishbone-classic slave, level interrupt o_mtip.
// Ack one cycle after request, never back-to-back; o_mtip lags the compare by one cycle.
module serv_mtimer
  import serv_mtimer_pkg::*;
#(
  parameter int PRESCALE       = 1,
  parameter     RESET_STRATEGY = "MINI"
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [1:0]  i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic        o_mtip
);

  localparam bit RST_EN = (RESET_STRATEGY != "NONE");

  logic       rst;
  logic       tick;
  logic       req;
  logic       wr;
  logic       rd;

  bus_state_t  state_q,  state_d;
  logic [63:0] mtime_q,  mtime_d;
  logic [63:0] cmp_q,    cmp_d;
  logic [31:0] shadow_q, shadow_d;
  logic [31:0] rdt_q,    rdt_d;
  logic        mtip_q,   mtip_d;

  assign rst = RST_EN && i_rst;

  serv_mtimer_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .i_clk  (i_clk),
    .i_rst  (rst),
    .o_tick (tick)
  );

  assign req = i_wb_cyc & i_wb_stb & (state_q == ST_IDLE);
  assign wr  = req & i_wb_we;
  assign rd  = req & ~i_wb_we;

  always_comb begin
    state_d  = state_q;
    mtime_d  = mtime_q;
    cmp_d    = cmp_q;
    shadow_d = shadow_q;
    rdt_d    = rdt_q;
    mtip_d   = (mtime_q >= cmp_q);

    case (state_q)
      ST_IDLE: if (req) state_d = ST_ACK;
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (tick) mtime_d = mtime_q + 64'd1;

    // A write to either mtime word overrides the whole increment, carry included.
    if (wr) begin
      case (i_wb_adr)
        MTIME_LO:    mtime_d = {mtime_q[63:32], byte_merge(mtime_q[31:0], i_wb_dat, i_wb_sel)};
        MTIME_HI:    mtime_d = {byte_merge(mtime_q[63:32], i_wb_dat, i_wb_sel), mtime_q[31:0]};
        MTIMECMP_LO: cmp_d   = {cmp_q[63:32], byte_merge(cmp_q[31:0], i_wb_dat, i_wb_sel)};
        MTIMECMP_HI: cmp_d   = {byte_merge(cmp_q[63:32], i_wb_dat, i_wb_sel), cmp_q[31:0]};
        default:     ;
      endcase
    end

    if (rd && (i_wb_adr == MTIME_LO)) shadow_d = mtime_q[63:32];

    if (req) begin
      case (i_wb_adr)
        MTIME_LO:    rdt_d = mtime_q[31:0];
        MTIME_HI:    rdt_d = shadow_q;
        MTIMECMP_LO: rdt_d = cmp_q[31:0];
        MTIMECMP_HI: rdt_d = cmp_q[63:32];
        default:     rdt_d = rdt_q;
      endcase
    end

    if (rst) begin
      state_d  = ST_IDLE;
      mtime_d  = '0;
      cmp_d    = MTIMECMP_RST;
      shadow_d = '0;
      rdt_d    = '0;
      mtip_d   = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    state_q  <= state_d;
    mtime_q  <= mtime_d;
    cmp_q    <= cmp_d;
    shadow_q <= shadow_d;
    rdt_q    <= rdt_d;
    mtip_q   <= mtip_d;
  end

  assign o_wb_ack = (state_q == ST_ACK);
  assign o_wb_rdt = rdt_q;
  assign o_mtip   = mtip_q;

endmodule

// File: tb/tb_serv_mtimer.sv
// Directed bench for serv_mtimer: one PRESCALE=1 and one PRESCALE=4 instance on shared bus inputs.
// Inputs are driven 1 time unit after each rising edge; outputs are sampled at the same point.
module tb_serv_mtimer;
  import serv_mtimer_pkg::*;

  logic        clk;
  logic        rst;
  logic [1:0]  wb_adr;
  logic [31:0] wb_dat;
  logic [3:0]  wb_sel;
  logic        wb_we;
  logic        wb_cyc;
  logic        wb_stb;
  logic [31:0] rdt1, rdt4;
  logic        ack1, ack4;
  logic        mtip1, mtip4;

  int checks = 0;
  int errors = 0;

  serv_mtimer #(.PRESCALE(1), .RESET_STRATEGY("MINI")) dut1 (
    .i_clk(clk), .i_rst(rst), .i_wb_adr(wb_adr), .i_wb_dat(wb_dat), .i_wb_sel(wb_sel),
    .i_wb_we(wb_we), .i_wb_cyc(wb_cyc), .i_wb_stb(wb_stb),
    .o_wb_rdt(rdt1), .o_wb_ack(ack1), .o_mtip(mtip1)
  );

  serv_mtimer #(.PRESCALE(4), .RESET_STRATEGY("MINI")) dut4 (
    .i_clk(clk), .i_rst(rst), .i_wb_adr(wb_adr), .i_wb_dat(wb_dat), .i_wb_sel(wb_sel),
    .i_wb_we(wb_we), .i_wb_cyc(wb_cyc), .i_wb_stb(wb_stb),
    .o_wb_rdt(rdt4), .o_wb_ack(ack4), .o_mtip(mtip4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One Wishbone access; returns the data both instances registered with their ack.
  task automatic xfer(input logic [1:0] adr, input logic we, input logic [31:0] dat,
                      input logic [3:0] sel, output logic [31:0] r1, output logic [31:0] r4);
    wb_adr = adr; wb_we = we; wb_dat = dat; wb_sel = sel;
    wb_cyc = 1'b1; wb_stb = 1'b1;
    step(1);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    chk("ack_raised", {62'd0, ack4, ack1}, 64'd3);
    r1 = rdt1;
    r4 = rdt4;
    step(1);
    chk("ack_dropped", {62'd0, ack4, ack1}, 64'd0);
  endtask

  task automatic wr(input logic [1:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] d1, d4;
    xfer(adr, 1'b1, dat, sel, d1, d4);
  endtask

  logic [31:0] r1, r4;
  int acks;

  initial begin
    rst = 1'b1; wb_adr = '0; wb_dat = '0; wb_sel = '0; wb_we = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0;
    step(2);
    rst = 1'b0;

    // Reset state
    chk("rst_ack",  {62'd0, ack4, ack1}, 64'd0);
    chk("rst_mtip", {62'd0, mtip4, mtip1}, 64'd0);
    chk("rst_rdt",  {rdt4, rdt1}, 64'd0);

    // Free run: ten edges after reset release mtime is 10
    step(10);
    xfer(MTIME_LO, 1'b0, '0, 4'hF, r1, r4);
    chk("run_lo", r1, 64'd10);
    chk("run_mtip", mtip1, 1'b0);

    // Compare match at 20; mtime is 5 when the last write returns
    wr(MTIME_LO, 32'd0, 4'hF);
    wr(MTIMECMP_HI, 32'd0, 4'hF);
    wr(MTIMECMP_LO, 32'd20, 4'hF);
    step(15);
    chk("mtip_at_20", mtip1, 1'b0);
    step(1);
    chk("mtip_rise", mtip1, 1'b1);
    step(1);
    chk("mtip_level", mtip1, 1'b1);
    wr(MTIMECMP_LO, 32'hFFFF_FFFF, 4'hF);
    chk("mtip_clear", mtip1, 1'b0);

    // Coherent 64-bit reads across the lo->hi carry
    wr(MTIME_HI, 32'd0, 4'hF);
    wr(MTIME_LO, 32'hFFFF_FFFF, 4'hF);
    xfer(MTIME_LO, 1'b0, '0, 4'hF, r1, r4);
    chk("carry_lo", r1, 64'd0);
    xfer(MTIME_HI, 1'b0, '0, 4'hF, r1, r4);
    chk("carry_hi", r1, 64'd1);
    wr(MTIME_HI, 32'd0, 4'hF);
    wr(MTIME_LO, 32'hFFFF_FFFD, 4'hF);
    xfer(MTIME_LO, 1'b0, '0, 4'hF, r1, r4);
    chk("shadow_lo", r1, 64'hFFFF_FFFE);
    xfer(MTIME_HI, 1'b0, '0, 4'hF, r1, r4);
    chk("shadow_hi", r1, 64'd0);
    xfer(MTIME_LO, 1'b0, '0, 4'hF, r1, r4);
    chk("post_lo", r1, 64'd2);
    xfer(MTIME_HI, 1'b0, '0, 4'hF, r1, r4);
    chk("post_hi", r1, 64'd1);

    // 64-bit wrap with mtimecmp at all ones
    wr(MTIMECMP_HI, 32'hFFFF_FFFF, 4'hF);
    wr(MTIME_HI, 32'hFFFF_FFFF, 4'hF);
    wr(MTIME_LO, 32'hFFFF_FFFE, 4'hF);
    chk("wrap_pre", mtip1, 1'b0);
    step(1);
    chk("wrap_max", mtip1, 1'b1);
    step(1);
    chk("wrap_zero", mtip1, 1'b0);
    xfer(MTIME_LO, 1'b0, '0, 4'hF, r1, r4);
    chk("wrap_lo", r1, 64'd1);
    xfer(MTIME_HI, 1'b0, '0, 4'hF, r1, r4);
    chk("wrap_hi", r1, 64'd0);

    // Byte-masked writes
    wr(MTIMECMP_LO, 32'd0, 4'hF);
    wr(MTIMECMP_LO, 32'h00AB_0000, 4'b0100);
    xfer(MTIMECMP_LO, 1'b0, '0, 4'hF, r1, r4);
    chk("byte2", r1, 64'h00AB_0000);
    wr(MTIMECMP_LO, 32'h1234_5678, 4'b0001);
    xfer(MTIMECMP_LO, 1'b0, '0, 4'hF, r1, r4);
    chk("byte0", r1, 64'h00AB_0078);
    xfer(MTIMECMP_HI, 1'b0, '0, 4'hF, r1, r4);
    chk("cmp_hi_live", r1, 64'hFFFF_FFFF);

    // Strobe held for six cycles
    wb_adr = MTIMECMP_LO; wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (ack1) acks++;
    end
    wb_cyc = 1'b0; wb_stb = 1'b0;
    chk("held_acks", acks, 64'd3);
    chk("held_rdt", rdt1, 64'h00AB_0078);
    step(1);

    // Reset during a pending write: nothing commits, everything back to reset values
    wb_adr = MTIMECMP_LO; wb_we = 1'b1; wb_dat = 32'h0000_0055; wb_sel = 4'hF;
    wb_cyc = 1'b1; wb_stb = 1'b1; rst = 1'b1;
    step(1);
    rst = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    chk("mid_rst_ack", {62'd0, ack4, ack1}, 64'd0);
    chk("mid_rst_rdt", {rdt4, rdt1}, 64'd0);
    chk("mid_rst_mtip", {62'd0, mtip4, mtip1}, 64'd0);
    xfer(MTIME_LO, 1'b0, '0, 4'hF, r1, r4);
    chk("mid_rst_mtime", {r4, r1}, 64'd0);
    xfer(MTIMECMP_LO, 1'b0, '0, 4'hF, r1, r4);
    chk("mid_rst_cmp", {r4, r1}, 64'hFFFF_FFFF_FFFF_FFFF);

    // PRESCALE=4: increments at 4, 8, 12, 16 edges after reset
    xfer(MTIME_LO, 1'b0, '0, 4'hF, r1, r4);
    chk("pre4_e4", r4, 64'd1);
    xfer(MTIME_LO, 1'b0, '0, 4'hF, r1, r4);
    chk("pre4_e6", r4, 64'd1);
    xfer(MTIME_LO, 1'b0, '0, 4'hF, r1, r4);
    chk("pre4_e8", r4, 64'd2);
    step(1);
    wr(MTIME_LO, 32'd5, 4'hF);
    xfer(MTIME_LO, 1'b0, '0, 4'hF, r1, r4);
    chk("pre4_wr_wins", r4, 64'd5);
    xfer(MTIME_LO, 1'b0, '0, 4'hF, r1, r4);
    chk("pre4_hold", r4, 64'd5);
    xfer(MTIME_LO, 1'b0, '0, 4'hF, r1, r4);
    chk("pre4_next", r4, 64'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
